// File: rtl/event_enc_pkg.sv
// ---------------------------------------------------------------------------
// event_enc_pkg
// Shared definitions for the event encoder slice.
//   state_t    : IDLE (no code held) / HOLD (code_out holds an undelivered code)
//   code_width : derives the code width from the number of request lines
//   DEFAULT_N  : default number of request lines
// ---------------------------------------------------------------------------
package event_enc_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // A single line still needs a one-bit code so the port never collapses
  // to zero width.
  function automatic int code_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/event_encoder_prio_select.sv
// ---------------------------------------------------------------------------
// prio_select
// Combinational rotating priority picker shared by fixed-priority and
// round-robin modes.
//   vec   : N-bit request vector to search
//   base  : index where the upward search starts (wraps past N-1 to 0)
//   found : at least one bit of vec is set
//   idx   : first set index at or above base, wrapping
// ---------------------------------------------------------------------------
module prio_select
  import event_enc_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int CODE_W = code_width(N)
) (
  input  logic [N-1:0]      vec,
  input  logic [CODE_W-1:0] base,
  output logic              found,
  output logic [CODE_W-1:0] idx
);

  logic [2*N-1:0]    doubled;
  logic [N-1:0]      rotated;
  logic [CODE_W-1:0] offset;

  // Rotate the vector right by base so the search always starts at bit 0;
  // shifting a doubled copy gives the wrap-around for free.
  assign doubled = {vec, vec} >> base;
  assign rotated = doubled[N-1:0];

  // Lowest set bit of the rotated vector. Scanning downward lets the last
  // hit (the lowest index) win.
  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = CODE_W'(i);
      end
    end
  end

  assign found = |vec;

  // N is a power of two, so CODE_W-bit addition wraps modulo N.
  assign idx = base + offset;

endmodule

// File: rtl/event_encoder.sv
// ---------------------------------------------------------------------------
// event_encoder
// Sequential N-to-CODE_W event encoder with a valid/ready code output.
// Requests are captured into a pending bitmap; one pending line at a time is
// loaded into code_out and held until the consumer accepts it.
//   clk         : rising-edge clock
//   rst         : synchronous, active-high reset
//   req_in      : event request lines, sampled every cycle
//   code_out    : index of the granted line, stable while valid_out is high
//   valid_out   : code_out holds an undelivered code
//   ready_in    : consumer accepts; transfer on valid_out && ready_in
//   pending_out : captured events not yet loaded into code_out
//   overrun_out : sticky, an event hit a line that was already pending
//   ovr_clr     : clears overrun_out (a new overrun in the same cycle wins)
// Parameters: N request lines (power of two), RR = 0 fixed priority with
// lowest index first, RR = 1 round-robin starting after the last loaded line.
// ---------------------------------------------------------------------------
module event_encoder
  import event_enc_pkg::*;
#(
  parameter  int N      = DEFAULT_N,
  parameter  int RR     = 0,
  localparam int CODE_W = code_width(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_in,
  output logic [CODE_W-1:0] code_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [N-1:0]      pending_out,
  output logic [N-1:0]      overrun_out,
  input  logic              ovr_clr
);

  state_t            state;
  logic [N-1:0]      pending;
  logic [N-1:0]      overrun;
  logic [CODE_W-1:0] last;
  logic [CODE_W-1:0] code;

  logic [CODE_W-1:0] base;
  logic              sel_found;
  logic [CODE_W-1:0] sel_idx;
  logic              load;
  logic [N-1:0]      load_mask;
  logic [N-1:0]      overrun_set;

  // Round-robin resumes one past the last loaded line; fixed priority always
  // searches from line 0. last resets to N-1 so the first search starts at 0.
  assign base = (RR != 0) ? (last + CODE_W'(1)) : '0;

  prio_select #(
    .N      (N),
    .CODE_W (CODE_W)
  ) u_select (
    .vec   (pending),
    .base  (base),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // A new code is loaded whenever the output slot is free (IDLE) or is being
  // emptied by a handshake this edge, and something is pending. Only the
  // registered pending value is considered, never req_in directly.
  always_comb begin
    load      = sel_found && ((state == IDLE) || ready_in);
    load_mask = '0;
    if (load) begin
      load_mask = N'(1) << sel_idx;
    end
  end

  // A request on a line that is pending and not being loaded this edge
  // collapses into the existing event. A request coinciding with the load of
  // its own line simply re-arms that line and is not an overrun.
  assign overrun_set = req_in & pending & ~load_mask;

  // Single state register block: pending capture, sticky overrun, the
  // IDLE/HOLD handshake FSM and the held code all advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      overrun <= '0;
      last    <= CODE_W'(N - 1);
      code    <= '0;
    end else begin
      pending <= (pending & ~load_mask) | req_in;
      overrun <= (ovr_clr ? '0 : overrun) | overrun_set;

      if (load) begin
        code  <= sel_idx;
        last  <= sel_idx;
        state <= HOLD;
      end else if ((state == HOLD) && ready_in) begin
        state <= IDLE;
      end
    end
  end

  assign code_out    = code;
  assign valid_out   = (state == HOLD);
  assign pending_out = pending;
  assign overrun_out = overrun;

endmodule

// File: tb/tb_event_encoder.sv
// ---------------------------------------------------------------------------
// tb_event_encoder
// Directed self-checking bench for event_encoder. Two instances share the
// same stimulus: dut0 runs fixed priority (RR=0), dut1 runs round-robin (RR=1).
// ---------------------------------------------------------------------------
module tb_event_encoder;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_in;
  logic         ready_in;
  logic         ovr_clr;

  logic [2:0]   code0, code1;
  logic         valid0, valid1;
  logic [N-1:0] pend0, pend1;
  logic [N-1:0] ovr0, ovr1;

  int checks = 0;
  int errors = 0;

  event_encoder #(.N(N), .RR(0)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req_in),
    .code_out    (code0),
    .valid_out   (valid0),
    .ready_in    (ready_in),
    .pending_out (pend0),
    .overrun_out (ovr0),
    .ovr_clr     (ovr_clr)
  );

  event_encoder #(.N(N), .RR(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req_in),
    .code_out    (code1),
    .valid_out   (valid1),
    .ready_in    (ready_in),
    .pending_out (pend1),
    .overrun_out (ovr1),
    .ovr_clr     (ovr_clr)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it, so outputs are sampled
  // away from the edge and the next inputs are driven well before the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req_in   = '0;
    ready_in = 1'b0;
    ovr_clr  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %0b/%0b expected 0/0", valid0, valid1);
    end
    checks++;
    if (code0 !== 3'd0 || code1 !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_code: got %0d/%0d expected 0/0", code0, code1);
    end
    checks++;
    if (pend0 !== 8'h00 || ovr0 !== 8'h00 || pend1 !== 8'h00 || ovr1 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_bitmaps: got pend %h/%h ovr %h/%h expected all 00",
               pend0, pend1, ovr0, ovr1);
    end
    // ready with nothing held must not create a code
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    checks++;
    if (valid0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_ready: got valid %0b expected 0", valid0);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_in = 8'b0000_0100;
    tick();
    req_in = '0;
    checks++;
    if (pend0 !== 8'h04 || valid0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_edge1: got pend %h valid %0b expected 04 0", pend0, valid0);
    end
    tick();
    checks++;
    if (valid0 !== 1'b1 || code0 !== 3'd2) begin
      errors++;
      $display("[TB] FAIL single_edge2: got valid %0b code %0d expected 1 2", valid0, code0);
    end
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    checks++;
    if (valid0 !== 1'b0 || pend0 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL single_accept: got valid %0b pend %h expected 0 00", valid0, pend0);
    end
  endtask

  task automatic test_fixed_priority();
    logic [2:0] expected [3];
    expected[0] = 3'd1;
    expected[1] = 3'd4;
    expected[2] = 3'd7;
    do_reset();
    req_in   = 8'b1001_0010;
    ready_in = 1'b1;
    tick();
    req_in = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (valid0 !== 1'b1 || code0 !== expected[k]) begin
        errors++;
        $display("[TB] FAIL fixed_code%0d: got valid %0b code %0d expected 1 %0d",
                 k, valid0, code0, expected[k]);
      end
    end
    tick();
    checks++;
    if (valid0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fixed_drain: got valid %0b expected 0", valid0);
    end
    ready_in = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_code;
    do_reset();
    req_in   = 8'hFF;
    ready_in = 1'b1;
    tick();
    for (int e = 2; e <= 11; e++) begin
      if (e == 11) begin
        req_in = '0;
      end
      tick();
      exp_code = 3'((e - 2) % 8);
      checks++;
      if (valid1 !== 1'b1 || code1 !== exp_code) begin
        errors++;
        $display("[TB] FAIL rr_edge%0d: got valid %0b code %0d expected 1 %0d",
                 e, valid1, code1, exp_code);
      end
    end
    // fixed priority under the same load keeps re-granting line 0
    checks++;
    if (code0 !== 3'd0) begin
      errors++;
      $display("[TB] FAIL fixed_starve: got code %0d expected 0", code0);
    end
    ready_in = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    req_in = 8'h08;
    tick();
    req_in = '0;
    tick();
    checks++;
    if (valid0 !== 1'b1 || code0 !== 3'd3) begin
      errors++;
      $display("[TB] FAIL ovr_setup: got valid %0b code %0d expected 1 3", valid0, code0);
    end
    req_in = 8'h08;
    tick();
    req_in = '0;
    checks++;
    if (code0 !== 3'd3 || pend0 !== 8'h08 || ovr0 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL ovr_pulse1: got code %0d pend %h ovr %h expected 3 08 00",
               code0, pend0, ovr0);
    end
    tick();
    req_in = 8'h08;
    tick();
    req_in = '0;
    checks++;
    if (code0 !== 3'd3 || valid0 !== 1'b1 || pend0 !== 8'h08 || ovr0 !== 8'h08) begin
      errors++;
      $display("[TB] FAIL ovr_pulse2: got code %0d valid %0b pend %h ovr %h expected 3 1 08 08",
               code0, valid0, pend0, ovr0);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    checks++;
    if (ovr0 !== 8'h00 || code0 !== 3'd3) begin
      errors++;
      $display("[TB] FAIL ovr_clear: got ovr %h code %0d expected 00 3", ovr0, code0);
    end
  endtask

  task automatic test_load_collision();
    do_reset();
    req_in = 8'h20;
    tick();
    tick();
    req_in = '0;
    checks++;
    if (valid0 !== 1'b1 || code0 !== 3'd5 || pend0 !== 8'h20 || ovr0 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL coll_load: got valid %0b code %0d pend %h ovr %h expected 1 5 20 00",
               valid0, code0, pend0, ovr0);
    end
    ready_in = 1'b1;
    tick();
    checks++;
    if (valid0 !== 1'b1 || code0 !== 3'd5 || pend0 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL coll_second: got valid %0b code %0d pend %h expected 1 5 00",
               valid0, code0, pend0);
    end
    tick();
    ready_in = 1'b0;
    checks++;
    if (valid0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL coll_drain: got valid %0b expected 0", valid0);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    req_in = 8'h0F;
    tick();
    req_in = '0;
    tick();
    req_in = 8'h01;
    tick();
    req_in = '0;
    checks++;
    if (valid0 !== 1'b1 || pend0 !== 8'h0F) begin
      errors++;
      $display("[TB] FAIL midop_setup: got valid %0b pend %h expected 1 0F", valid0, pend0);
    end
    rst      = 1'b1;
    ready_in = 1'b1;
    tick();
    rst      = 1'b0;
    ready_in = 1'b0;
    checks++;
    if (valid0 !== 1'b0 || code0 !== 3'd0 || pend0 !== 8'h00 || ovr0 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midop_reset: got valid %0b code %0d pend %h ovr %h expected 0 0 00 00",
               valid0, code0, pend0, ovr0);
    end
    tick();
    tick();
    checks++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_quiet: got valid %0b/%0b expected 0/0", valid0, valid1);
    end
  endtask

  initial begin
    rst      = 1'b1;
    req_in   = '0;
    ready_in = 1'b0;
    ovr_clr  = 1'b0;
    test_reset();
    test_single();
    test_fixed_priority();
    test_round_robin();
    test_overrun();
    test_load_collision();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
